iir_inverse_filter: RTL and testbench
=====================================

# iir_inverse_filter

First-order inverse (whitening) filter that exactly undoes the team's 4-bit first-order IIR section: given the IIR output stream y[n] and the same coefficient a, it recovers x[n] = y[n] − (a·y[n−1])[3:0] mod 16. It sits downstream of the IIR section, or in the verification loopback, as its decoder counterpart. It uses a 4-cycle sequential signed shift-add multiplier instead of a combinational array, and it exchanges samples over valid/ready handshakes on both sides.

## Interface
- No parameters; all data widths are fixed at 4 bits signed (two's complement).
- Reset is rst, synchronous, active-high; the clock is clk.
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous active-high reset
- a  input  4  signed coefficient; sampled only on the input handshake edge
- y_in  input  4  signed filtered sample y[n]
- in_valid  input  1  y_in and a are valid
- in_ready  output  1  block can accept a sample; high only in IDLE and while rst is low
- x_out  output  4  signed recovered sample x[n]
- out_valid  output  1  x_out is valid
- out_ready  input  1  downstream accepts x_out
- busy  output  1  high in MUL or OUT

## Operation
- Registers:
  - y_prev (4b): previous accepted y; reset value 0.
  - y_cur, a_lat (4b each).
  - prod (8b signed accumulator).
  - cnt (2b).
  - x_out (4b): reset value 0.
- FSM states IDLE, MUL and OUT; reset state is IDLE.
- IDLE: in_ready=1. On in_valid & in_ready: latch y_cur<=y_in, a_lat<=a, prod<=0, cnt<=0, then go to MUL.
- MUL: the multiplicand is a_lat sign-extended to 8 bits; the multiplier bits are y_prev[i].
  - Iteration i=cnt, one per cycle.
  - For i=0..2: if y_prev[i], prod += sext(a_lat)<<i.
  - For i=3: if y_prev[3], prod −= sext(a_lat)<<3 (two's-complement sign weight).
  - After the i=3 edge, prod equals the exact signed product a_lat·y_prev in the range [−56, 64].
- On the same edge as i=3: x_out <= y_cur − prod_final[3:0] (4-bit wrap, no saturation), out_valid<=1, then go to OUT.
- OUT: x_out and out_valid are held stable.
  - On out_ready: y_prev<=y_cur, out_valid<=0, then go to IDLE.
  - While out_ready=0, stay in OUT. in_ready=0, and in_valid is ignored.
- Arithmetic is modulo 16 throughout. The low 4 bits of the product are identical for signed and unsigned interpretation. The result is a bit-exact inverse of y = x + (a·y_prev)[3:0].
- The first sample after reset sees y_prev=0, so x_out = y_in.
- a changing outside the input handshake has no effect.
- Reset mid-operation (any state):
  - Next state is IDLE; out_valid=0, x_out=0, y_prev=0, busy=0.
  - Any in-flight sample is discarded.
  - in_ready is 0 during the rst cycle and 1 in the first cycle after rst deasserts.

## Timing
- Input handshake at edge E0, multiply edges E1–E4. out_valid is high after E4: latency is 4 cycles from accept to out_valid.
- With out_ready held high, output handshake occurs at E5 and in_ready rises after E5. The next accept is at E6, so minimum throughput is 1 sample per 6 cycles.
- in_ready and out_valid are never high in the same cycle.
- No combinational path runs from in_valid or out_ready to any output. in_ready and busy decode state only.

## Test plan
- Identity: a=0, y stream 5, −3 (0101, 1101) → x_out 5, −3. Latency exactly 4 cycles per sample; period 6 with out_ready=1.
- Positive coefficient: after reset, a=2, y=3 → x=3. Then a=2, y=7 → prod=6, x=1 (0001).
- Negative coefficient: y_prev=3, a=−1 (1111), y=−2 (1110) → prod=−3, x=1.
- Wrap: y_prev=7, a=7, y=−8 → prod=49 (0x31), x=−9 mod 16 = 7 (0111). Separately, y_prev=−8, a=−8 → prod=64, low bits 0, x=y.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in OUT → x_out and out_valid stable, in_ready=0, in_valid pulses ignored, y_prev unchanged until the handshake.
  - Assert rst during the second MUL cycle → out_valid=0 next cycle. Then a=3, y=4 → x=4 (y_prev cleared).
- Loopback: 200 random (x, a) pairs through the IIR section, then through this block with the same a → recovered stream equals x bit-exactly after both sections are reset together.

Source files
------------

// File: rtl/iir_inverse_filter.sv
// iir_inverse_filter
// First-order inverse (whitening) filter for the 4-bit first-order IIR section.
// It recovers x[n] = y[n] - (a*y[n-1])[3:0] mod 16 from the IIR output stream.
// The product a*y_prev is formed by a 4-cycle sequential signed shift-add
// multiplier. Samples move over valid/ready handshakes on both sides.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   a          signed coefficient, captured on the input handshake only
//   y_in       signed filtered sample y[n]
//   in_valid   y_in / a valid
//   in_ready   block can accept a sample (IDLE and not in reset)
//   x_out      signed recovered sample x[n]
//   out_valid  x_out valid
//   out_ready  downstream accepts x_out
//   busy       a sample is in flight (MUL or OUT)
module iir_inverse_filter (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] y_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] x_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0] state;
  logic [3:0] y_prev, y_cur, a_lat;
  logic [7:0] prod, addend, prod_next;
  logic [1:0] cnt;

  // One multiplier bit per cycle. Bit 3 carries the negative two's-complement
  // weight, so that partial product is subtracted instead of added.
  always_comb begin
    addend    = {{4{a_lat[3]}}, a_lat} << cnt;
    prod_next = prod;
    if (y_prev[cnt]) begin
      if (cnt == 2'd3) prod_next = prod - addend;
      else             prod_next = prod + addend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      y_prev    <= 4'd0;
      y_cur     <= 4'd0;
      a_lat     <= 4'd0;
      prod      <= 8'd0;
      cnt       <= 2'd0;
      x_out     <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_cur <= y_in;
            a_lat <= a;
            prod  <= 8'd0;
            cnt   <= 2'd0;
            state <= MUL;
          end
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // Only the low nibble of the product matters: mod-16 arithmetic.
            x_out     <= y_cur - prod_next[3:0];
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            y_prev    <= y_cur;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state == MUL) || (state == OUT);

endmodule

// File: tb/tb_iir_inverse_filter.sv
// Self-checking bench for iir_inverse_filter: directed vector table, hand-written
// backpressure/reset sequences and a randomized IIR->inverse loopback.
module tb_iir_inverse_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, y_in, x_out;
  logic       in_valid, in_ready, out_valid, out_ready, busy;

  iir_inverse_filter dut (
    .clk(clk), .rst(rst), .a(a), .y_in(y_in), .in_valid(in_valid),
    .in_ready(in_ready), .x_out(x_out), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] y;
    logic [3:0] x;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one sample, wait for it to be accepted and for out_valid.
  // Returns x_out, latency in cycles and the cycle of the accept edge.
  task automatic send(input logic [3:0] av, input logic [3:0] yv,
                      output logic [3:0] xv, output int lat, output int acc_cyc);
    int t;
    @(negedge clk);
    a = av; y_in = yv; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    in_valid = 1'b0;
    a = 4'($urandom);      // must not affect the sample in flight
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    xv = x_out;
  endtask

  // Complete the output handshake after optional stall cycles.
  task automatic take(input int stall);
    repeat (stall) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [3:0] iir_step(input logic [3:0] xv, input logic [3:0] av,
                                          input logic [3:0] yp);
    int p;
    p = $signed(av) * $signed(yp);
    return 4'(int'(xv) + p);
  endfunction

  initial begin
    vec_t vt[8];
    logic [3:0] xv, hold_x, yp, xs, ys, as;
    int lat, acc, prev_acc, stall;

    rst = 1'b1; a = 0; y_in = 0; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_x_out", int'(x_out), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // Identity with latency and period check.
    send(4'd0, 4'd5, xv, lat, acc);
    check("ident0_x", int'(xv), 5);
    check("ident0_lat", lat, 4);
    check("ident0_in_ready_low", int'(in_ready), 0);
    check("ident0_busy", int'(busy), 1);
    prev_acc = acc;
    take(0);
    send(4'd0, 4'd13, xv, lat, acc);
    check("ident1_x", int'(xv), 13);
    check("ident1_lat", lat, 4);
    check("period", acc - prev_acc, 6);
    take(0);

    // Directed table, applied after a fresh reset (y_prev chain starts at 0).
    vt[0] = '{4'd2,  4'd3,  4'd3};   // first sample: x = y
    vt[1] = '{4'd2,  4'd7,  4'd1};   // prod 6
    vt[2] = '{4'd0,  4'd3,  4'd3};   // sets y_prev = 3
    vt[3] = '{4'd15, 4'd14, 4'd1};   // a=-1, y=-2: prod -3
    vt[4] = '{4'd0,  4'd7,  4'd7};   // sets y_prev = 7
    vt[5] = '{4'd7,  4'd8,  4'd7};   // prod 49, wrap
    vt[6] = '{4'd0,  4'd8,  4'd8};   // sets y_prev = -8
    vt[7] = '{4'd8,  4'd5,  4'd5};   // prod 64, low nibble 0
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(vt[i].a, vt[i].y, xv, lat, acc);
      check($sformatf("vec%0d_x", i), int'(xv), int'(vt[i].x));
      take(0);
    end

    // Backpressure: hold OUT for 3 cycles, pulse in_valid meanwhile.
    send(4'd0, 4'd6, xv, lat, acc);      // y_prev before: 5 -> x = 6
    check("bp_x", int'(xv), 6);
    hold_x = x_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; y_in = 4'd1; a = 4'd1;
      @(posedge clk); #1;
      check("bp_hold_x", int'(x_out), int'(hold_x));
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      in_valid = 1'b0;
    end
    take(0);
    send(4'd1, 4'd9, xv, lat, acc);      // y_prev must be 6: 9-6 = 3
    check("bp_yprev_x", int'(xv), 3);
    take(0);

    // Reset during the second MUL cycle.
    @(negedge clk);
    a = 4'd5; y_in = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;                  // E0 accept
    in_valid = 1'b0;
    @(posedge clk); #1;                  // E1
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_x_out", int'(x_out), 0);
    check("mrst_busy", int'(busy), 0);
    check("mrst_in_ready", int'(in_ready), 0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("mrst_in_ready_after", int'(in_ready), 1);
    send(4'd3, 4'd4, xv, lat, acc);
    check("mrst_x", int'(xv), 4);
    take(0);

    // Loopback: IIR model feeds the DUT; DUT must recover x exactly.
    do_reset();
    yp = 4'd0;
    for (int i = 0; i < 200; i++) begin
      xs = 4'($urandom);
      as = 4'($urandom);
      ys = iir_step(xs, as, yp);
      yp = ys;
      send(as, ys, xv, lat, acc);
      if (xv !== xs || lat != 4) begin
        check($sformatf("loop%0d_x", i), int'(xv), int'(xs));
        check($sformatf("loop%0d_lat", i), lat, 4);
      end else begin
        nvec++;
      end
      stall = $urandom_range(0, 2);
      take(stall);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
